// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared types for the bit-serial subtractor.
//   state_t : controller state encoding (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Single-bit combinational full subtractor: d = x - y - bin.
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when x < y, or when x == y and a borrow is already pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, LSB first,
// one bit per clock through a single full-subtractor cell.
// Ports:
//   clk    : system clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   start  : request, accepted only while ready=1
//   a, b   : operands, sampled on the accept edge
//   bin    : borrow in, sampled on the accept edge
//   ready  : high only in IDLE
//   done   : one-cycle pulse when diff/borrow hold a new result
//   diff   : difference, held from done until the next result
//   borrow : borrow out of the MSB, held like diff
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bo;
    logic             w_last;

    assign w_last = (r_cnt == LAST);

    full_subtractor u_cell (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_br  <= bin;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Publish on the last bit so the visible result only
                    // changes together with the DONE transition.
                    if (w_last) begin
                        r_diff   <= {w_d, r_res[WIDTH-1:1]};
                        r_borrow <= w_bo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             bin   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             ready;
    logic             done;
    logic             borrow;
    logic [WIDTH-1:0] diff;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .ready  (ready),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    // Reference model: an accepted request becomes a pending result computed
    // with plain (WIDTH+1)-bit arithmetic; the device is busy for WIDTH+1
    // cycles and the result appears in the last of them.
    int               m_left   = 0;
    logic [WIDTH:0]   m_pend   = '0;
    logic [WIDTH-1:0] m_diff   = '0;
    logic             m_borrow = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= WIDTH + 1;
                m_pend <= {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                {m_borrow, m_diff} <= m_pend;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model ready",  {31'd0, ready},  {31'd0, (m_left == 0)});
        chk("model done",   {31'd0, done},   {31'd0, (m_left == 1)});
        chk("model diff",   {28'd0, diff},   {28'd0, m_diff});
        chk("model borrow", {31'd0, borrow}, {31'd0, m_borrow});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT, required event not seen", name);
    endtask

    task automatic wait_ready;
        for (int i = 0; i < 20; i++) begin
            if (ready) return;
            tick();
        end
        timeout("wait ready");
    endtask

    task automatic do_op(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ibin, input logic [WIDTH-1:0] exp_d, input logic exp_bo);
        int lat;
        wait_ready();
        a = ia; b = ib; bin = ibin; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            chk({tag, " ready low"}, {31'd0, ready}, 32'd0);
        end
        if (lat == 0) timeout({tag, " done"});
        else begin
            chk({tag, " latency"}, lat, 32'd5);
            chk({tag, " ready in done"}, {31'd0, ready}, 32'd0);
            chk({tag, " diff"}, {28'd0, diff}, {28'd0, exp_d});
            chk({tag, " borrow"}, {31'd0, borrow}, {31'd0, exp_bo});
        end
    endtask

    initial begin
        int n_done;
        int last;
        logic [WIDTH-1:0] got;

        repeat (3) tick();
        chk("reset ready",  {31'd0, ready},  32'd1);
        chk("reset done",   {31'd0, done},   32'd0);
        chk("reset diff",   {28'd0, diff},   32'd0);
        chk("reset borrow", {31'd0, borrow}, 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("9-3",     4'd9, 4'd3, 1'b0, 4'h6, 1'b0);
        do_op("3-9",     4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
        do_op("0-0-1",   4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
        do_op("F-F",     4'hF, 4'hF, 1'b0, 4'h0, 1'b0);
        do_op("F-0-1",   4'hF, 4'h0, 1'b1, 4'hE, 1'b0);

        // start reasserted during RUN with different operands is ignored
        wait_ready();
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        tick();
        a = 4'd1; b = 4'd1; bin = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        n_done = 0;
        got = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                got = diff;
            end
        end
        chk("ignored start done count", n_done, 32'd1);
        chk("ignored start diff", {28'd0, got}, 32'h6);

        // reset in the middle of an operation
        wait_ready();
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort ready",  {31'd0, ready},  32'd1);
        chk("abort done",   {31'd0, done},   32'd0);
        chk("abort diff",   {28'd0, diff},   32'd0);
        chk("abort borrow", {31'd0, borrow}, 32'd0);
        tick();
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort no done", n_done, 32'd0);

        // start held high: back-to-back operations every WIDTH+2 cycles
        tick();
        wait_ready();
        a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
        last = -1;
        for (int k = 0; k < 4; k++) begin
            n_done = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done) begin
                    n_done = 1;
                    break;
                end
            end
            if (n_done == 0) timeout("held start done");
            else begin
                chk("held diff",   {28'd0, diff},   32'h3);
                chk("held borrow", {31'd0, borrow}, 32'd0);
                if (last >= 0) chk("held period", cyc - last, 32'd6);
                last = cyc;
            end
        end
        tick();
        start = 1'b0;

        // randomized traffic, including operand changes mid-run
        repeat (500) begin
            tick();
            start = 1'($urandom_range(0, 1));
            a     = 4'($urandom);
            b     = 4'($urandom);
            bin   = 1'($urandom);
        end
        start = 1'b0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial WIDTH-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock through a single full-subtractor cell with a registered borrow.
- Sequential counterpart to the combinational ripple carry adder: trades latency for area.
- Used where operand arrival is sparse and a start/done handshake is acceptable.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
a  input  WIDTH  minuend, sampled on the accept edge
b  input  WIDTH  subtrahend, sampled on the accept edge
bin  input  1  borrow-in, sampled on the accept edge
ready  output  1  high only in IDLE
done  output  1  single-cycle pulse: result valid
diff  output  WIDTH  difference, held stable from done until the next accept
borrow  output  1  final borrow-out (1 when a < b + bin), held like diff

Behaviour:
- Reset: asynchronous on rst_n low.
  - state=IDLE, ready=1, done=0, diff=0, borrow=0.
  - Internal shift registers, borrow register and counter cleared.
  - Reset during RUN aborts the operation with no done pulse.
- FSM states:
  - IDLE: start=1 loads a, b into shift registers, bin into the borrow register, counter=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: each cycle processes bit 0 of the shift registers.
    - d = a0 ^ b0 ^ br
    - bo = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into the result register from the MSB side; operands shift right; br <= bo; counter++.
    - After the WIDTH-th bit (counter == WIDTH-1), go to DONE.
  - DONE: done=1 for exactly this cycle; diff and borrow are valid. Always goes to IDLE next cycle.
- Latency: accept edge at cycle 0, done high during cycle WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start is ignored while in RUN or DONE (ready=0). The request is not queued. Operand changes during RUN have no effect.
- diff and borrow update only on the DONE transition. They are not visible mid-operation; the previous result is held until then.
- Arithmetic: modulo 2^WIDTH. borrow equals the borrow out of the MSB. No overflow flag.
- Counter width: $clog2(WIDTH).

Decomposition:
- Package serial_subtractor_pkg: state enum (IDLE, RUN, DONE), 2-bit encoding IDLE=0, RUN=1, DONE=2.
- Sub-module full_subtractor (purely combinational):
  - inputs x, y, bin; outputs d, bout
  - instantiated once for the datapath bit cell.

Test Plan:
- WIDTH=4, a=9, b=3, bin=0, start pulse -> done at cycle 5 after accept, diff=4'h6, borrow=0; ready low cycles 1-5.
- a=3, b=9, bin=0 -> diff=4'hA, borrow=1.
- a=0, b=0, bin=1 -> diff=4'hF, borrow=1; a=4'hF, b=4'hF, bin=0 -> diff=0, borrow=0.
- Start a=9, b=3; reassert start with a=1, b=1 during RUN -> ignored, result 4'h6, exactly one done pulse.
- Start a=9, b=3; drive rst_n low at cycle 2 -> immediate ready=1, done=0, diff=0, borrow=0, no done pulse afterwards.
- Start held high continuously with a=5, b=2 -> one operation per 6 cycles, each done shows diff=4'h3, borrow=0; a new accept occurs on the cycle after done.
